// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction-memory loader and fetch controller.
//   LOAD : accepts 32-bit big-endian program words from a loader and writes
//          them into byte-wide instruction memory, one byte per cycle.
//   RUN  : drives pc into a combinational-read memory and captures the
//          returned word into the IF/ID register (1-cycle fetch latency).
//          Supports stall (hold) and redirect (jump/branch, flushes IF/ID).
//          A fetched all-zero word marks end of program and halts.
//   HALT : everything frozen until reset.
//
// Optional feature macro: IMEM_BOUND_CHECK_EN
//   When defined, a RUN fetch at a misaligned pc or beyond the last full word
//   raises a sticky fault and halts. Otherwise fault is tied to 0.
//
// Ports
//   clk, reset            : rising-edge clock, async active-low reset
//   load_valid/load_word  : loader word offer; load_ready = accept this cycle
//   load_done             : one-cycle pulse, program image complete
//   mem_we/waddr/wdata    : byte write port into instruction memory
//   pc / inst_code        : fetch address out, instruction word back
//   stall                 : hold IF/ID and pc
//   redirect_valid/_pc    : taken jump/branch target
//   if_valid/if_inst/if_pc: IF/ID register contents
//   state                 : LOAD=0, RUN=1, HALT=2
//   fault                 : out-of-range fetch (bound check build only)
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
   parameter int unsigned MEM_BYTES = 36,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_valid,
   input  logic [31:0] load_word,
   output logic        load_ready,
   input  logic        load_done,
   output logic        mem_we,
   output logic [31:0] mem_waddr,
   output logic [7:0]  mem_wdata,
   output logic [31:0] pc,
   input  logic [31:0] inst_code,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic [1:0]  state,
   output logic        fault
);

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [31:0] MEM_SIZE = 32'(MEM_BYTES);

   // Big-endian byte pick: index 0 is the most significant byte.
   function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         2'd3:    b = word[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_wptr;
   logic [31:0] r_word;
   logic [2:0]  r_byte_cnt;    // bytes of r_word already emitted (1..4)
   logic        r_busy;        // a word is being streamed out byte-wise
   logic        r_done;        // load_done seen while busy
   logic        r_load_ready;
   logic        r_mem_we;
   logic [31:0] r_mem_waddr;
   logic [7:0]  r_mem_wdata;
   logic        r_if_valid;
   logic [31:0] r_if_inst;
   logic [31:0] r_if_pc;

   logic        w_ptr_ok;
   logic [7:0]  w_emit_byte;

   // Writes past the end of memory are dropped and the pointer parks there.
   assign w_ptr_ok    = (r_wptr < MEM_SIZE);
   // First byte comes straight from the accepted word, the rest from r_word.
   assign w_emit_byte = r_busy ? sel_byte(r_word, r_byte_cnt[1:0]) : load_word[31:24];

`ifdef IMEM_BOUND_CHECK_EN
   localparam logic [31:0] LAST_WORD = MEM_SIZE - 32'd4;
   logic r_fault;
   logic w_oob;
   assign w_oob = (r_pc > LAST_WORD) || (r_pc[1:0] != 2'b00);
   assign fault = r_fault;
`else
   assign fault = 1'b0;
`endif

   // Controller FSM: loader, byte writer, fetch stage and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_LOAD;
         r_pc         <= RESET_PC;
         r_wptr       <= 32'd0;
         r_word       <= 32'd0;
         r_byte_cnt   <= 3'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_load_ready <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_waddr  <= 32'd0;
         r_mem_wdata  <= 8'd0;
         r_if_valid   <= 1'b0;
         r_if_inst    <= 32'd0;
         r_if_pc      <= 32'd0;
`ifdef IMEM_BOUND_CHECK_EN
         r_fault      <= 1'b0;
`endif
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            ST_LOAD: begin
               if (r_busy) begin
                  if (load_done) begin
                     r_done <= 1'b1;
                  end
                  if (r_byte_cnt == 3'd4) begin
                     // Word finished: now honour any pending done.
                     r_busy <= 1'b0;
                     if (r_done || load_done) begin
                        r_state <= ST_RUN;
                        r_pc    <= RESET_PC;
                        r_done  <= 1'b0;
                     end else begin
                        r_load_ready <= 1'b1;
                     end
                  end else begin
                     r_mem_we    <= w_ptr_ok;
                     r_mem_waddr <= r_wptr;
                     r_mem_wdata <= w_emit_byte;
                     if (w_ptr_ok) begin
                        r_wptr <= r_wptr + 32'd1;
                     end
                     r_byte_cnt <= r_byte_cnt + 3'd1;
                  end
               end else if (load_valid && r_load_ready) begin
                  r_word       <= load_word;
                  r_busy       <= 1'b1;
                  r_done       <= load_done;
                  r_load_ready <= 1'b0;
                  r_byte_cnt   <= 3'd1;
                  r_mem_we     <= w_ptr_ok;
                  r_mem_waddr  <= r_wptr;
                  r_mem_wdata  <= w_emit_byte;
                  if (w_ptr_ok) begin
                     r_wptr <= r_wptr + 32'd1;
                  end
               end else if (load_done) begin
                  r_state      <= ST_RUN;
                  r_pc         <= RESET_PC;
                  r_load_ready <= 1'b0;
               end else begin
                  r_load_ready <= 1'b1;
               end
            end
            ST_RUN: begin
               if (redirect_valid) begin
                  r_pc       <= redirect_pc;
                  r_if_valid <= 1'b0;
               end else if (stall) begin
                  r_pc <= r_pc;
               end
`ifdef IMEM_BOUND_CHECK_EN
               else if (w_oob) begin
                  r_fault    <= 1'b1;
                  r_state    <= ST_HALT;
                  r_if_valid <= 1'b0;
               end
`endif
               else if (inst_code == 32'h0) begin
                  r_state    <= ST_HALT;
                  r_if_valid <= 1'b0;
               end else begin
                  r_if_inst  <= inst_code;
                  r_if_pc    <= r_pc;
                  r_if_valid <= 1'b1;
                  r_pc       <= r_pc + 32'd4;
               end
            end
            ST_HALT: begin
               r_if_valid   <= 1'b0;
               r_load_ready <= 1'b0;
            end
            default: begin
               // Unused encoding behaves as HALT.
               r_state      <= ST_HALT;
               r_if_valid   <= 1'b0;
               r_load_ready <= 1'b0;
            end
         endcase
      end
   end

   assign load_ready = r_load_ready;
   assign mem_we     = r_mem_we;
   assign mem_waddr  = r_mem_waddr;
   assign mem_wdata  = r_mem_wdata;
   assign pc         = r_pc;
   assign if_valid   = r_if_valid;
   assign if_inst    = r_if_inst;
   assign if_pc      = r_if_pc;
   assign state      = r_state;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Self-checking bench for imem_fetch_ctrl: directed load/run scenarios plus a
// randomized stall/redirect run compared against a behavioural fetch model.
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

   localparam int          MB  = 36;
   localparam logic [31:0] RPC = 32'h0;
`ifdef IMEM_BOUND_CHECK_EN
   localparam bit BOUND_EN = 1'b1;
`else
   localparam bit BOUND_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_valid = 1'b0;
   logic [31:0] load_word = 32'h0;
   logic        load_ready;
   logic        load_done = 1'b0;
   logic        mem_we;
   logic [31:0] mem_waddr;
   logic [7:0]  mem_wdata;
   logic [31:0] pc;
   logic [31:0] inst_code;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [1:0]  state;
   logic        fault;

   always #5 clk = ~clk;

   imem_fetch_ctrl #(.MEM_BYTES(MB), .RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset),
      .load_valid(load_valid), .load_word(load_word), .load_ready(load_ready),
      .load_done(load_done),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .pc(pc), .inst_code(inst_code),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
      .state(state), .fault(fault)
   );

   // Instruction memory written by the DUT, read combinationally at pc.
   logic [7:0] imem [0:63];
   always @(posedge clk) begin
      if (mem_we && mem_waddr < 32'd64) imem[mem_waddr[5:0]] <= mem_wdata;
   end
   always_comb begin
      inst_code = 32'h0;
      if (pc <= 32'(MB - 4))
         inst_code = {imem[pc[5:0]], imem[pc[5:0] + 6'd1], imem[pc[5:0] + 6'd2], imem[pc[5:0] + 6'd3]};
   end

   // Reference state
   logic [7:0]  exp_mem [0:63];
   int          b_ptr;
   logic [31:0] m_pc, m_inst, m_ipc;
   bit          m_v, m_halt, m_fault;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] m_word(input logic [31:0] a);
      if (a <= 32'(MB - 4))
         return {exp_mem[a[5:0]], exp_mem[a[5:0] + 6'd1], exp_mem[a[5:0] + 6'd2], exp_mem[a[5:0] + 6'd3]};
      return 32'h0;
   endfunction

   // One RUN cycle of the fetch rules, applied to the model.
   task automatic model_step(input bit s, input bit rv, input logic [31:0] rpc);
      logic [31:0] wd;
      if (m_halt) begin
         m_v = 1'b0;
      end else if (rv) begin
         m_pc = rpc;
         m_v  = 1'b0;
      end else if (!s) begin
         wd = m_word(m_pc);
         if (BOUND_EN && (m_pc > 32'(MB - 4) || m_pc[1:0] != 2'b00)) begin
            m_fault = 1'b1; m_halt = 1'b1; m_v = 1'b0;
         end else if (wd == 32'h0) begin
            m_halt = 1'b1; m_v = 1'b0;
         end else begin
            m_ipc = m_pc; m_inst = wd; m_v = 1'b1; m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic run_cycle(input bit s, input bit rv, input logic [31:0] rpc);
      stall = s; redirect_valid = rv; redirect_pc = rpc;
      model_step(s, rv, rpc);
      step();
      stall = 1'b0; redirect_valid = 1'b0;
      check_eq("run_pc", pc, m_pc);
      check_eq("run_if_valid", {31'd0, if_valid}, {31'd0, m_v});
      check_eq("run_if_pc", if_pc, m_ipc);
      check_eq("run_if_inst", if_inst, m_inst);
      check_eq("run_state", {30'd0, state}, m_halt ? 32'd2 : 32'd1);
      check_eq("run_fault", {31'd0, fault}, {31'd0, m_fault});
   endtask

   task automatic do_reset();
      load_valid = 1'b0; load_done = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
      reset = 1'b0;
      step();
      check_eq("rst_state", {30'd0, state}, 32'd0);
      check_eq("rst_load_ready", {31'd0, load_ready}, 32'd0);
      check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check_eq("rst_waddr", mem_waddr, 32'd0);
      check_eq("rst_wdata", {24'd0, mem_wdata}, 32'd0);
      check_eq("rst_pc", pc, RPC);
      check_eq("rst_if_valid", {31'd0, if_valid}, 32'd0);
      check_eq("rst_if_inst", if_inst, 32'd0);
      check_eq("rst_if_pc", if_pc, 32'd0);
      check_eq("rst_fault", {31'd0, fault}, 32'd0);
      b_ptr = 0;
      m_pc = RPC; m_inst = 32'h0; m_ipc = 32'h0; m_v = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 10 && !load_ready; i++) step();
      check_eq("load_ready_wait", {31'd0, load_ready}, 32'd1);
   endtask

   // Offer one word, check its 4 byte writes and the cycle after.
   task automatic load_w(input logic [31:0] w, input bit done);
      logic [31:0] tmp;
      bit          ok;
      tmp = w;
      wait_ready();
      repeat ($urandom_range(0, 2)) step();
      for (int k = 0; k < 4; k++) begin
         if (k == 0) begin load_valid = 1'b1; load_word = w; end
         if (done && k == 2) load_done = 1'b1;
         step();
         load_valid = 1'b0; load_done = 1'b0;
         ok = (b_ptr < MB);
         check_eq("wr_we", {31'd0, mem_we}, {31'd0, ok});
         if (ok) begin
            check_eq("wr_addr", mem_waddr, 32'(b_ptr));
            check_eq("wr_data", {24'd0, mem_wdata}, {24'd0, tmp[31 - 8*k -: 8]});
            exp_mem[b_ptr] = tmp[31 - 8*k -: 8];
            b_ptr++;
         end
      end
      step();
      check_eq("wr_end_we", {31'd0, mem_we}, 32'd0);
      if (done) begin
         check_eq("load_to_run", {30'd0, state}, 32'd1);
         check_eq("run_start_pc", pc, RPC);
      end else begin
         check_eq("ready_again", {31'd0, load_ready}, 32'd1);
      end
   endtask

   logic [31:0] prog [0:7];

   task automatic load_prog();
      for (int i = 0; i < 8; i++) load_w(prog[i], i == 7);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit          s, rv, did_rd;
      int          n_st, guard;
      logic [31:0] rpc;

      for (int i = 0; i < 64; i++) exp_mem[i] = 8'h00;
      prog[0] = 32'h8d61000c; prog[1] = 32'h68281000; prog[2] = 32'h00430820;
      prog[3] = 32'hac220004; prog[4] = 32'h1022fffe; prog[5] = 32'h20420001;
      prog[6] = 32'h08000002; prog[7] = 32'h00000000;

      // Single word then done: byte order, then RUN from RESET_PC.
      do_reset();
      load_w(32'h8d61000c, 1'b1);
      run_cycle(1'b0, 1'b0, 32'h0);
      check_eq("first_fetch_inst", if_inst, 32'h8d61000c);

      // Program run with a 3-cycle stall at pc=8 and redirect+stall at pc=16.
      do_reset();
      load_prog();
      n_st = 0; did_rd = 1'b0; guard = 0;
      while (!m_halt && guard < 60) begin
         s = 1'b0; rv = 1'b0; rpc = 32'h0;
         if (m_pc == 32'd8 && n_st < 3) begin s = 1'b1; n_st++; end
         if (m_pc == 32'd16 && !did_rd) begin rv = 1'b1; rpc = 32'd8; s = 1'b1; did_rd = 1'b1; end
         run_cycle(s, rv, rpc);
         if (s && !rv) begin
            check_eq("stall_pc", pc, 32'd8);
            check_eq("stall_inst", if_inst, 32'h68281000);
         end
         if (rv) begin
            check_eq("redirect_pc", pc, 32'd8);
            check_eq("redirect_flush", {31'd0, if_valid}, 32'd0);
         end
         guard++;
      end
      check_eq("halt_state", {30'd0, state}, 32'd2);
      check_eq("halt_pc", pc, 32'd28);
      run_cycle(1'b0, 1'b1, 32'd4);

      // Random program overflowing memory, random stall/redirect.
      do_reset();
      for (int i = 0; i < 10; i++) load_w($urandom | 32'h1, i == 9);
      for (int i = 0; i < 120 && !m_halt; i++)
         run_cycle(($urandom % 4) == 0, ($urandom % 12) == 0, 32'($urandom_range(0, 9)) * 32'd4);
      for (int i = 0; i < 40 && !m_halt; i++) run_cycle(1'b0, 1'b0, 32'h0);
      check_eq("rand_halt", {30'd0, state}, 32'd2);

      // Reset during the second byte of a word write.
      do_reset();
      wait_ready();
      load_valid = 1'b1; load_word = 32'hdeadbeef;
      step();
      load_valid = 1'b0;
      step();
      check_eq("mid_we_before", {31'd0, mem_we}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check_eq("mid_rst_we", {31'd0, mem_we}, 32'd0);
      check_eq("mid_rst_state", {30'd0, state}, 32'd0);
      check_eq("mid_rst_ready", {31'd0, load_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step();
      check_eq("post_rst_ready", {31'd0, load_ready}, 32'd1);
      b_ptr = 0;
      load_w(32'h12345678, 1'b0);

      // Redirect beyond memory: fault only in the bound-checked build.
      do_reset();
      load_prog();
      run_cycle(1'b0, 1'b0, 32'h0);
      run_cycle(1'b0, 1'b0, 32'h0);
      run_cycle(1'b0, 1'b1, 32'd36);
      for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 32'h0);
      check_eq("oob_fault", {31'd0, fault}, {31'd0, BOUND_EN});
      check_eq("oob_state", {30'd0, state}, 32'd2);
      check_eq("oob_if_valid", {31'd0, if_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
